pc_sequencer: RTL and testbench

//  Fetch/next-PC stage feeding the control unit. Holds the PC and requests instruction words.

---
 rtl/mips_pkg.sv | 25 ++
 rtl/next_pc_mux.sv | 33 +++
 rtl/pc_sequencer.sv | 91 +++++++++
 tb/tb_pc_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS-subset definitions: sequencer FSM encodings, PC step and opcode constants.
package mips_pkg;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    EXEC     = 2'd1,
    WAIT_MEM = 2'd2
  } state_e;

  localparam logic [1:0] ST_FETCH    = 2'd0;
  localparam logic [1:0] ST_EXEC     = 2'd1;
  localparam logic [1:0] ST_WAIT_MEM = 2'd2;

  localparam int PC_STEP = 4;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_JMI   = 6'b110000;

  function automatic logic word_misaligned(input logic [1:0] low_bits);
    return low_bits != 2'b00;
  endfunction

endpackage

// File: rtl/next_pc_mux.sv
// Combinational next-PC select for a non-indirect EXEC: jump > taken branch > pc_plus4.
module next_pc_mux #(
  parameter int PC_WIDTH = 32
) (
  input  logic [PC_WIDTH-1:0] pc_plus4,
  input  logic [31:0]         ir,
  input  logic                jump,
  input  logic                branch,
  input  logic                alu_zero,
  output logic [PC_WIDTH-1:0] next_pc
);

  logic [PC_WIDTH-1:0] jump_target;
  logic [PC_WIDTH-1:0] branch_offset;
  logic [PC_WIDTH-1:0] branch_target;
  logic                unused_opc;

  // Jump keeps the upper region bits of pc_plus4; only 29..32-bit PCs are legal.
  assign jump_target   = {pc_plus4[PC_WIDTH-1:28], ir[25:0], 2'b00};
  assign branch_offset = {{(PC_WIDTH-18){ir[15]}}, ir[15:0], 2'b00};
  assign branch_target = pc_plus4 + branch_offset;
  assign unused_opc    = ^ir[31:26];

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = jump_target;
    end else if (branch && alu_zero) begin
      next_pc = branch_target;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch / next-PC stage: holds PC and IR, runs FETCH -> EXEC -> (FETCH | WAIT_MEM).
module pc_sequencer
  import mips_pkg::*;
#(
  parameter int                  PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ready,
  input  logic [31:0]         imem_rdata,
  output logic [31:0]         ir,
  output logic [5:0]          op_code,
  output logic                instr_valid,
  output logic [PC_WIDTH-1:0] pc_plus4,
  input  logic                jump,
  input  logic                branch,
  input  logic                pc_control,
  input  logic                alu_zero,
  input  logic                stall,
  input  logic                dmem_rvalid,
  input  logic [31:0]         dmem_rdata,
  output logic                misalign_err,
  output logic [1:0]          fsm_state
);

  // Handshakes: imem_req is held in FETCH until imem_ready; a word is taken only on the
  // cycle both are high. dmem_rvalid is a one-cycle qualifier honoured only in WAIT_MEM.

  logic [1:0]          state;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] next_pc;
  logic                run_q;

  next_pc_mux #(.PC_WIDTH(PC_WIDTH)) u_next_pc_mux (
    .pc_plus4 (pc_plus4),
    .ir       (ir),
    .jump     (jump),
    .branch   (branch),
    .alu_zero (alu_zero),
    .next_pc  (next_pc)
  );

  assign pc_plus4     = pc + PC_WIDTH'(PC_STEP);
  assign imem_addr    = pc;
  assign op_code      = ir[31:26];
  assign instr_valid  = (state == ST_EXEC);
  // run_q keeps the request low while reset is held and releases it on the first edge after.
  assign imem_req     = (state == ST_FETCH) && run_q;
  assign misalign_err = (state == ST_WAIT_MEM) && dmem_rvalid && word_misaligned(dmem_rdata[1:0]);
  assign fsm_state    = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_FETCH;
      pc    <= RESET_PC;
      ir    <= '0;
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
      case (state)
        ST_FETCH: begin
          if (imem_req && imem_ready) begin
            ir    <= imem_rdata;
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (!stall) begin
            if (pc_control) begin
              state <= ST_WAIT_MEM;
            end else begin
              pc    <= next_pc;
              state <= ST_FETCH;
            end
          end
        end
        ST_WAIT_MEM: begin
          if (dmem_rvalid) begin
            pc    <= {dmem_rdata[PC_WIDTH-1:2], 2'b00};
            state <= ST_FETCH;
          end
        end
        default: state <= ST_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential fetch, jump, beq, indirect jump, stall, reset.
module tb_pc_sequencer;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] ir;
  logic [5:0]  op_code;
  logic        instr_valid;
  logic [31:0] pc_plus4;
  logic        jump, branch, pc_control, alu_zero, stall;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        misalign_err;
  logic [1:0]  fsm_state;

  int checks = 0;
  int errors = 0;
  int misalign_pulses = 0;

  localparam logic [31:0] J_WORD   = {OPC_J, 26'h0100000};
  localparam logic [31:0] BEQ_WORD = {OPC_BEQ, 10'd0, 16'hFFFF};
  localparam logic [31:0] JMI_WORD = {OPC_JMI, 26'd0};

  pc_sequencer #(.PC_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ready   (imem_ready),
    .imem_rdata   (imem_rdata),
    .ir           (ir),
    .op_code      (op_code),
    .instr_valid  (instr_valid),
    .pc_plus4     (pc_plus4),
    .jump         (jump),
    .branch       (branch),
    .pc_control   (pc_control),
    .alu_zero     (alu_zero),
    .stall        (stall),
    .dmem_rvalid  (dmem_rvalid),
    .dmem_rdata   (dmem_rdata),
    .misalign_err (misalign_err),
    .fsm_state    (fsm_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (observed running, expected done)");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_bit(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Waits (bounded) for a fetch request, hands over one word and checks it landed in ir.
  task automatic fetch_word(input logic [31:0] w);
    int n = 0;
    while (imem_req !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    check_bit("fetch_req", imem_req, 1'b1);
    imem_ready = 1'b1;
    imem_rdata = w;
    tick();
    imem_ready = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    check_word("fetch_ir", ir, w);
    check_bit("fetch_valid", instr_valid, 1'b1);
    check_word("fetch_opcode", {26'd0, op_code}, {26'd0, w[31:26]});
  endtask

  // Runs an indirect jump whose memory word is returned on the first WAIT_MEM cycle.
  task automatic jmi_to(input logic [31:0] target);
    fetch_word(JMI_WORD);
    pc_control = 1'b1;
    tick();
    pc_control = 1'b0;
    check_word("jmi_state", {30'd0, fsm_state}, {30'd0, ST_WAIT_MEM});
    dmem_rvalid = 1'b1;
    dmem_rdata  = target;
    tick();
    dmem_rvalid = 1'b0;
    check_word("jmi_pc", imem_addr, {target[31:2], 2'b00});
  endtask

  initial begin
    rst_n = 1'b0;
    imem_ready = 1'b0; imem_rdata = '0;
    jump = 1'b0; branch = 1'b0; pc_control = 1'b0; alu_zero = 1'b0; stall = 1'b0;
    dmem_rvalid = 1'b0; dmem_rdata = '0;
    repeat (2) tick();

    check_bit("rst_imem_req", imem_req, 1'b0);
    check_bit("rst_instr_valid", instr_valid, 1'b0);
    check_bit("rst_misalign", misalign_err, 1'b0);
    check_word("rst_ir", ir, 32'h0);
    check_word("rst_addr", imem_addr, 32'h0);
    check_word("rst_state", {30'd0, fsm_state}, {30'd0, ST_FETCH});

    rst_n = 1'b1;
    tick();
    check_bit("req_after_release", imem_req, 1'b1);

    // Sequential fetch 0,4,8; imem_ready held high through EXEC must not overwrite ir.
    for (int i = 0; i < 3; i++) begin
      check_word("t1_addr", imem_addr, 32'(i * 4));
      fetch_word(32'h20 + 32'(i));
      check_word("t1_pc_plus4", pc_plus4, 32'(i * 4 + 4));
      imem_ready = 1'b1;
      tick();
      imem_ready = 1'b0;
      check_bit("t1_one_exec", instr_valid, 1'b0);
      check_word("t1_ir_hold", ir, 32'h20 + 32'(i));
    end

    // Jump from 0x0040_0010.
    jmi_to(32'h0040_0010);
    fetch_word(J_WORD);
    jump = 1'b1;
    tick();
    jump = 1'b0;
    check_word("t2_jump", imem_addr, 32'h0040_0000);

    // beq with imm -1: taken returns to 0x100, not taken falls through to 0x104.
    jmi_to(32'h0000_0100);
    fetch_word(BEQ_WORD);
    branch = 1'b1; alu_zero = 1'b1;
    tick();
    branch = 1'b0; alu_zero = 1'b0;
    check_word("t3_beq_taken", imem_addr, 32'h0000_0100);
    fetch_word(BEQ_WORD);
    branch = 1'b1; alu_zero = 1'b0;
    tick();
    branch = 1'b0;
    check_word("t3_beq_not_taken", imem_addr, 32'h0000_0104);

    // Indirect jump with three idle WAIT_MEM cycles and a misaligned target.
    fetch_word(JMI_WORD);
    pc_control = 1'b1;
    tick();
    pc_control = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_bit("t4_wait_req", imem_req, 1'b0);
      check_bit("t4_wait_valid", instr_valid, 1'b0);
      check_word("t4_wait_pc", imem_addr, 32'h0000_0104);
      if (misalign_err) misalign_pulses++;
      tick();
    end
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h0000_2003;
    #1;
    if (misalign_err) misalign_pulses++;
    tick();
    dmem_rvalid = 1'b0;
    if (misalign_err) misalign_pulses++;
    check_word("t4_misalign_pulses", 32'(misalign_pulses), 32'd1);
    check_word("t4_pc", imem_addr, 32'h0000_2000);
    check_bit("t4_req", imem_req, 1'b1);

    // Stall for two cycles holds PC and ir; jump goes on the first unstalled cycle.
    fetch_word(J_WORD);
    jump = 1'b1; stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_bit("t5_stall_valid", instr_valid, 1'b1);
      check_word("t5_stall_pc", imem_addr, 32'h0000_2000);
      check_word("t5_stall_ir", ir, J_WORD);
    end
    stall = 1'b0;
    tick();
    jump = 1'b0;
    check_word("t5_jump", imem_addr, 32'h0040_0000);
    check_bit("t5_valid_after", instr_valid, 1'b0);

    // Top word address: pc_plus4 wraps to 0; dmem_rvalid in FETCH is ignored.
    jmi_to(32'hFFFF_FFFC);
    check_word("wrap_pc_plus4", pc_plus4, 32'h0);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h0000_0003;
    #1;
    check_bit("fetch_rvalid_no_err", misalign_err, 1'b0);
    fetch_word({OPC_RTYPE, 26'h20});
    dmem_rvalid = 1'b0;
    check_word("fetch_rvalid_pc", imem_addr, 32'hFFFF_FFFC);
    tick();
    check_word("wrap_pc", imem_addr, 32'h0);

    // Reset during WAIT_MEM abandons the indirect jump.
    fetch_word(JMI_WORD);
    pc_control = 1'b1;
    tick();
    pc_control = 1'b0;
    check_word("t6_in_wait", {30'd0, fsm_state}, {30'd0, ST_WAIT_MEM});
    rst_n = 1'b0;
    #1;
    check_word("t6_rst_state", {30'd0, fsm_state}, {30'd0, ST_FETCH});
    check_word("t6_rst_ir", ir, 32'h0);
    check_bit("t6_rst_req", imem_req, 1'b0);
    tick();
    rst_n = 1'b1;
    tick();
    check_word("t6_addr", imem_addr, 32'h0);
    check_bit("t6_req", imem_req, 1'b1);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h0000_5557;
    #1;
    check_bit("t6_late_rvalid_err", misalign_err, 1'b0);
    tick();
    dmem_rvalid = 1'b0;
    check_word("t6_late_rvalid_pc", imem_addr, 32'h0);
    check_word("t6_state", {30'd0, fsm_state}, {30'd0, ST_FETCH});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
